// File: rtl/pooling_stream_kxk.sv
`default_nettype none
// ============================================================================
//  Module      : pooling_stream_kxk
//  Description : Streaming KxK non-overlapping average/max pooling over an
//                NxN raster-order feature map, one pixel per beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module pooling_stream_kxk #(
    parameter int N  = 8,
    parameter int K  = 2,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] pix_in,
    output logic                 out_valid,
    output logic signed [DW-1:0] pix_out,
    output logic                 finish
);

    localparam int c_LOGK = (K == 4) ? 2 : 1;
    localparam int c_SH   = 2 * c_LOGK;
    localparam int c_AW   = DW + c_SH;
    localparam int c_NW   = N / K;
    localparam int c_CW   = (N > 1) ? $clog2(N) : 1;
    localparam int c_IW   = (c_NW > 1) ? $clog2(c_NW) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    if (((N % K) != 0) || ((K != 2) && (K != 4))) begin : g_param_check
        $error("pooling_stream_kxk: K must be 2 or 4 and divide N");
    end

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic                     r_mode;
    logic [c_CW-1:0]          r_row;
    logic [c_CW-1:0]          r_col;
    logic signed [c_AW-1:0]   r_acc [c_NW];
    logic                     r_out_valid;
    logic signed [DW-1:0]     r_pix_out;
    logic                     r_finish;

    logic                     w_accept;
    logic                     w_start_acc;
    logic                     w_last;
    logic                     w_win_first;
    logic                     w_win_last;
    logic [c_IW-1:0]          w_idx;
    logic signed [c_AW-1:0]   w_pix_ext;
    logic signed [c_AW-1:0]   w_acc_cur;
    logic signed [c_AW-1:0]   w_acc_new;
    logic signed [DW-1:0]     w_pooled;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_RUN;
            c_RUN:   if (w_accept && w_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == c_RUN);
    end

    // ---------------- Datapath ----------------
    assign w_accept    = in_valid && (r_state == c_RUN);
    assign w_start_acc = start && (r_state == c_IDLE);
    assign w_last      = (r_row == c_LAST) && (r_col == c_LAST);
    assign w_win_first = (r_row[c_LOGK-1:0] == '0) && (r_col[c_LOGK-1:0] == '0);
    assign w_win_last  = (&r_row[c_LOGK-1:0]) && (&r_col[c_LOGK-1:0]);
    assign w_idx       = c_IW'(r_col >> c_LOGK);
    assign w_pix_ext   = {{c_SH{pix_in[DW-1]}}, pix_in};
    assign w_acc_cur   = r_acc[w_idx];

    always_comb begin
        w_acc_new = w_acc_cur;
        if (w_win_first) begin
            w_acc_new = w_pix_ext;
        end else if (r_mode) begin
            w_acc_new = (w_pix_ext > w_acc_cur) ? w_pix_ext : w_acc_cur;
        end else begin
            w_acc_new = w_acc_cur + w_pix_ext;
        end
    end

    // Taking the top DW bits is the arithmetic shift by 2*log2(K), i.e. floor division.
    assign w_pooled = r_mode ? w_acc_new[DW-1:0] : w_acc_new[c_SH +: DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_pix_out   <= '0;
            r_finish    <= 1'b0;
            for (int i = 0; i < c_NW; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_finish    <= 1'b0;
            if (w_start_acc) begin
                r_mode <= mode;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_accept) begin
                r_acc[w_idx] <= w_acc_new;
                if (r_col == c_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_win_last) begin
                    r_out_valid <= 1'b1;
                    r_pix_out   <= w_pooled;
                    r_finish    <= w_last;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign pix_out   = r_pix_out;
    assign finish    = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_pooling_stream_kxk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pooling_stream_kxk
//  Description : Randomized self-checking bench for pooling_stream_kxk with a
//                window-level reference model (N=4/K=2 and N=8/K=4 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pooling_stream_kxk;

    typedef struct {
        int tag;
        int val;
        int fin;
        int cyc;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        mode;
    logic        in_valid;
    logic signed [15:0] pix_in;
    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic signed [15:0] pix_out_a, pix_out_b;
    logic        finish_a, finish_b;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_stray = 0;
    int   frame_pix [64];
    rec_t got_q [$];
    rec_t exp_q [$];
    int   exp_cyc_q [$];

    pooling_stream_kxk #(.N(4), .K(2), .DW(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .in_ready(in_ready_a),
        .in_valid(in_valid), .pix_in(pix_in), .out_valid(out_valid_a),
        .pix_out(pix_out_a), .finish(finish_a)
    );

    pooling_stream_kxk #(.N(8), .K(4), .DW(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .in_ready(in_ready_b),
        .in_valid(in_valid), .pix_in(pix_in), .out_valid(out_valid_b),
        .pix_out(pix_out_b), .finish(finish_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid_a) got_q.push_back('{0, int'(pix_out_a), int'(finish_a), cyc});
        if (out_valid_b) got_q.push_back('{1, int'(pix_out_b), int'(finish_b), cyc});
        if ((finish_a && !out_valid_a) || (finish_b && !out_valid_b)) n_stray++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q--;
        return q;
    endfunction

    // Expected pooled outputs for every window whose last pixel lies in the first n_send beats.
    function automatic void model(input int sel, input int n, input int k, input bit md, input int n_send);
        for (int orow = 0; orow < n / k; orow++) begin
            for (int ocol = 0; ocol < n / k; ocol++) begin
                int sum, mx, v, res, last_idx;
                last_idx = (orow * k + k - 1) * n + ocol * k + k - 1;
                if (last_idx < n_send) begin
                    sum = 0;
                    mx  = frame_pix[orow * k * n + ocol * k];
                    for (int dy = 0; dy < k; dy++) begin
                        for (int dx = 0; dx < k; dx++) begin
                            v = frame_pix[(orow * k + dy) * n + ocol * k + dx];
                            sum += v;
                            if (v > mx) mx = v;
                        end
                    end
                    res = md ? mx : floor_div(sum, k * k);
                    exp_q.push_back('{sel, res,
                        ((orow == n / k - 1) && (ocol == n / k - 1)) ? 1 : 0, 0});
                end
            end
        end
    endfunction

    task automatic send_frame(input int sel, input bit md, input int n, input int k,
                              input int n_send, input int pct, input bit glitch, input bit b2b);
        int  i, budget, c0, r, c;
        bit  rdy;
        model(sel, n, k, md, n_send);
        if (b2b) check("b2b_finish", int'(sel != 0 ? finish_b : finish_a), 1);
        else begin
            @(posedge clk); #1;
        end
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        mode     = md;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        i = 0;
        budget = 0;
        while (i < n_send && budget < n * n * 40 + 100) begin
            in_valid = ($urandom_range(0, 99) < pct);
            pix_in   = 16'(frame_pix[i]);
            if (glitch) begin
                if ($urandom_range(0, 2) == 0) begin
                    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
                end else begin
                    start_a = 1'b0;
                    start_b = 1'b0;
                end
                mode = 1'($urandom_range(0, 1));
            end
            rdy = (sel != 0) ? in_ready_b : in_ready_a;
            c0  = cyc;
            @(posedge clk); #1;
            if (in_valid && rdy) begin
                r = i / n;
                c = i % n;
                if ((r % k == k - 1) && (c % k == k - 1)) exp_cyc_q.push_back(c0 + 1);
                i++;
            end
            budget++;
        end
        if (i < n_send) check("accept_timeout", i, n_send);
        in_valid = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        mode     = md;
    endtask

    task automatic compare_outputs();
        repeat (4) @(posedge clk);
        #1;
        check("out_count", got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
            check("out_dut", got_q[j].tag, exp_q[j].tag);
            check("out_val", got_q[j].val, exp_q[j].val);
            check("out_finish", got_q[j].fin, exp_q[j].fin);
            if (j < exp_cyc_q.size()) check("out_latency_cycle", got_q[j].cyc, exp_cyc_q[j]);
        end
        check("stray_finish", n_stray, 0);
        got_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        n_stray = 0;
    endtask

    task automatic rand_fill(input int n);
        for (int i = 0; i < n * n; i++) frame_pix[i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    initial begin
        int prev_sel, sel;
        bit md, b2b;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1'b0; in_valid = 1'b0; pix_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_a", int'(in_ready_a), 0);
        check("rst_out_valid_a", int'(out_valid_a), 0);
        check("rst_pix_out_a", int'(pix_out_a), 0);
        check("rst_finish_a", int'(finish_a), 0);
        check("rst_in_ready_b", int'(in_ready_b), 0);
        check("rst_pix_out_b", int'(pix_out_b), 0);
        rst = 1'b0;

        // in_valid while idle must be ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            pix_in   = 16'($urandom);
            @(posedge clk); #1;
            check("idle_in_ready", int'(in_ready_a | in_ready_b), 0);
        end
        in_valid = 1'b0;
        compare_outputs();

        // Average, ramp 0..15
        for (int i = 0; i < 16; i++) frame_pix[i] = i;
        send_frame(0, 1'b0, 4, 2, 16, 100, 1'b0, 1'b0);
        compare_outputs();

        // Max, alternating sign, then an all-negative frame
        for (int i = 0; i < 16; i++) frame_pix[i] = (i % 2 == 0) ? i : -i;
        send_frame(0, 1'b1, 4, 2, 16, 100, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) frame_pix[i] = i - 16;
        send_frame(0, 1'b1, 4, 2, 16, 100, 1'b0, 1'b0);
        compare_outputs();

        // Average floors toward -inf
        rand_fill(4);
        frame_pix[0] = -1; frame_pix[1] = -1; frame_pix[4] = -1; frame_pix[5] = 0;
        frame_pix[2] = -4; frame_pix[3] = -4; frame_pix[6] = -4; frame_pix[7] = -4;
        send_frame(0, 1'b0, 4, 2, 16, 100, 1'b0, 1'b0);
        compare_outputs();

        // Gapped input with spurious start/mode activity mid-frame
        for (int i = 0; i < 16; i++) frame_pix[i] = i;
        send_frame(0, 1'b0, 4, 2, 16, 50, 1'b1, 1'b0);
        compare_outputs();

        // Reset after 7 pixels aborts the frame
        rand_fill(4);
        send_frame(0, 1'b0, 4, 2, 7, 100, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready_a), 0);
        check("abort_out_valid", int'(out_valid_a), 0);
        check("abort_pix_out", int'(pix_out_a), 0);
        check("abort_finish", int'(finish_a), 0);
        compare_outputs();
        rand_fill(4);
        send_frame(0, 1'b0, 4, 2, 16, 100, 1'b0, 1'b0);
        compare_outputs();

        // K=4 extremes, back to back with start in the finish cycle
        for (int i = 0; i < 64; i++) frame_pix[i] = 32767;
        send_frame(1, 1'b0, 8, 4, 64, 100, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) frame_pix[i] = -32768;
        send_frame(1, 1'b0, 8, 4, 64, 100, 1'b0, 1'b1);
        rand_fill(8);
        send_frame(1, 1'b1, 8, 4, 64, 100, 1'b0, 1'b1);
        compare_outputs();

        // Randomized frames across both geometries
        prev_sel = -1;
        for (int f = 0; f < 16; f++) begin
            sel = int'($urandom_range(0, 1));
            md  = 1'($urandom_range(0, 1));
            b2b = (sel == prev_sel) && ($urandom_range(0, 1) == 1);
            rand_fill(sel != 0 ? 8 : 4);
            if (sel != 0) send_frame(1, md, 8, 4, 64, int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)), b2b);
            else          send_frame(0, md, 4, 2, 16, int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)), b2b);
            prev_sel = sel;
        end
        compare_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
